// File: rtl/rx_char_fifo_p_pkg.sv
// Shared character codes and entry format for the receive character queue.
package rx_char_fifo_p_pkg;

  localparam logic [1:0] EOP = 2'b01;
  localparam logic [1:0] EEP = 2'b10;

  // Entry layout matches dat_o: {lchar flag, character}.
  typedef struct packed {
    logic       lchar;
    logic [7:0] ch;
  } entry_t;

  function automatic logic is_eop(input logic [1:0] code);
    return (code == EOP) || (code == EEP);
  endfunction

endpackage

// File: rtl/rx_fifo_ram.sv
// Queue storage: one synchronous write port, asynchronous read, no reset.
module rx_fifo_ram
  import rx_char_fifo_p_pkg::*;
#(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [DEPTH_LOG2-1:0] i_waddr,
  input  entry_t                i_wdata,
  input  logic [DEPTH_LOG2-1:0] i_raddr,
  output entry_t                o_rdata
);

  entry_t r_mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/rx_char_fifo_p.sv
// Receive character queue: filters control characters, counts stored packet
// terminators, and serves reads through a registered strobe/acknowledge pair.
module rx_char_fifo_p
  import rx_char_fifo_p_pkg::*;
#(
  parameter int DEPTH_LOG2  = 3,
  parameter int AFULL_LEVEL = (2**DEPTH_LOG2) - 2,
  parameter int KEEP_CTRL   = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                nchar,
  input  logic                lchar,
  input  logic [7:0]          char_i,
  input  logic                stb_i,
  output logic                ack_o,
  output logic [8:0]          dat_o,
  output logic                full_o,
  output logic                empty_o,
  output logic                almost_full_o,
  output logic [DEPTH_LOG2:0] level_o,
  output logic [DEPTH_LOG2:0] pkt_cnt_o,
  output logic                ovf_o,
  input  logic                ovf_clr_i
);

  localparam int                  LW      = DEPTH_LOG2 + 1;
  localparam logic [LW-1:0]       FULL_LV = LW'(2**DEPTH_LOG2);
  localparam logic [LW-1:0]       AF_LV   = LW'(AFULL_LEVEL);
  localparam logic [LW-1:0]       ONE     = LW'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

  logic                  r_ack;
  logic                  r_ovf;
  logic [LW-1:0]         r_level;
  logic [LW-1:0]         r_pkt;
  logic [DEPTH_LOG2-1:0] r_wp;
  logic [DEPTH_LOG2-1:0] r_rp;

  logic   w_keep;
  logic   w_char_eop;
  logic   w_we;
  logic   w_full;
  logic   w_empty;
  logic   w_pop;
  logic   w_wr_acc;
  logic   w_ovf_evt;
  logic   w_st_pkt;
  logic   w_pop_pkt;
  entry_t w_wdata;
  entry_t w_head;

  assign w_keep     = (KEEP_CTRL != 0);
  assign w_char_eop = is_eop(char_i[1:0]);
  assign w_we       = nchar | (lchar & (w_char_eop | w_keep));
  assign w_full     = (r_level == FULL_LV);
  assign w_empty    = (r_level == '0);

  // An ack that lands on an empty queue pops nothing; a write then waits a cycle.
  assign w_pop      = r_ack & ~w_empty;
  assign w_wr_acc   = w_we & (~w_full | w_pop);
  assign w_ovf_evt  = w_we & w_full & ~w_pop;

  // lchar dominates when both strobes are high, so the entry is a control code.
  assign w_wdata.lchar = lchar;
  assign w_wdata.ch    = char_i;

  assign w_st_pkt  = w_wr_acc & lchar & w_char_eop;
  assign w_pop_pkt = w_pop & w_head.lchar & is_eop(w_head.ch[1:0]);

  rx_fifo_ram #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_wr_acc),
    .i_waddr (r_wp),
    .i_wdata (w_wdata),
    .i_raddr (r_rp),
    .o_rdata (w_head)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ack <= 1'b0;
      r_wp  <= '0;
      r_rp  <= '0;
    end else begin
      r_ack <= stb_i;
      if (w_wr_acc) r_wp <= r_wp + PTR_ONE;
      if (w_pop)    r_rp <= r_rp + PTR_ONE;
    end
  end

  // Occupancy is tracked by its own counter rather than pointer difference.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_level <= '0;
    end else begin
      case ({w_wr_acc, w_pop})
        2'b10:   r_level <= r_level + ONE;
        2'b01:   r_level <= r_level - ONE;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pkt <= '0;
    end else begin
      case ({w_st_pkt, w_pop_pkt})
        2'b10:   r_pkt <= r_pkt + ONE;
        2'b01:   r_pkt <= r_pkt - ONE;
        default: r_pkt <= r_pkt;
      endcase
    end
  end

  // A fresh overflow outranks a clear in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          r_ovf <= 1'b0;
    else if (w_ovf_evt) r_ovf <= 1'b1;
    else if (ovf_clr_i) r_ovf <= 1'b0;
  end

  assign ack_o         = r_ack;
  assign dat_o         = w_head;
  assign full_o        = w_full;
  assign empty_o       = w_empty;
  assign almost_full_o = (r_level >= AF_LV);
  assign level_o       = r_level;
  assign pkt_cnt_o     = r_pkt;
  assign ovf_o         = r_ovf;

endmodule

// File: tb/tb_rx_char_fifo_p.sv
// Bench for rx_char_fifo_p: directed vector table, corner-case sequences and
// random traffic, all compared against a queue-based reference model.
module tb_rx_char_fifo_p;

  localparam int DL    = 3;
  localparam int DEPTH = 8;
  localparam int AFL   = 6;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       nchar = 1'b0;
  logic       lchar = 1'b0;
  logic [7:0] char_i = 8'h00;
  logic       stb_i = 1'b0;
  logic       ovf_clr_i = 1'b0;
  logic       ack_o;
  logic [8:0] dat_o;
  logic       full_o;
  logic       empty_o;
  logic       almost_full_o;
  logic [DL:0] level_o;
  logic [DL:0] pkt_cnt_o;
  logic       ovf_o;

  rx_char_fifo_p #(
    .DEPTH_LOG2  (DL),
    .AFULL_LEVEL (AFL),
    .KEEP_CTRL   (0)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .nchar         (nchar),
    .lchar         (lchar),
    .char_i        (char_i),
    .stb_i         (stb_i),
    .ack_o         (ack_o),
    .dat_o         (dat_o),
    .full_o        (full_o),
    .empty_o       (empty_o),
    .almost_full_o (almost_full_o),
    .level_o       (level_o),
    .pkt_cnt_o     (pkt_cnt_o),
    .ovf_o         (ovf_o),
    .ovf_clr_i     (ovf_clr_i)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: a plain queue of stored entries plus two flags.
  logic [8:0] mq[$];
  logic       m_ack = 1'b0;
  logic       m_ovf = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_pkt();
    int n = 0;
    foreach (mq[i])
      if (mq[i][8] && (mq[i][1:0] == 2'b01 || mq[i][1:0] == 2'b10)) n++;
    return n;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_ack = 1'b0;
    m_ovf = 1'b0;
  endtask

  task automatic model_edge(input logic nc, input logic lc, input logic [7:0] ch,
                            input logic st, input logic cl);
    logic eop, we, pop, room;
    eop  = (ch[1:0] == 2'b01) || (ch[1:0] == 2'b10);
    we   = nc | (lc & eop);
    pop  = m_ack && (mq.size() > 0);
    room = (mq.size() < DEPTH) || pop;
    if (pop) void'(mq.pop_front());
    if (we && room) mq.push_back({lc, ch});
    if (we && !room) m_ovf = 1'b1;
    else if (cl)     m_ovf = 1'b0;
    m_ack = st;
  endtask

  task automatic check_model(input string tag);
    int sz;
    sz = mq.size();
    chk({tag, " ack"},   32'(ack_o),         32'(m_ack));
    chk({tag, " level"}, 32'(level_o),       sz);
    chk({tag, " empty"}, 32'(empty_o),       32'(sz == 0));
    chk({tag, " full"},  32'(full_o),        32'(sz == DEPTH));
    chk({tag, " afull"}, 32'(almost_full_o), 32'(sz >= AFL));
    chk({tag, " pkt"},   32'(pkt_cnt_o),     m_pkt());
    chk({tag, " ovf"},   32'(ovf_o),         32'(m_ovf));
    if (sz > 0) chk({tag, " dat"}, 32'(dat_o), 32'(mq[0]));
  endtask

  task automatic step(input logic nc, input logic lc, input logic [7:0] ch,
                      input logic st, input logic cl, input string tag);
    @(negedge clk);
    nchar = nc; lchar = lc; char_i = ch; stb_i = st; ovf_clr_i = cl;
    @(posedge clk);
    model_edge(nc, lc, ch, st, cl);
    #1;
    check_model(tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    nchar = 0; lchar = 0; char_i = 0; stb_i = 0; ovf_clr_i = 0;
    reset = 1'b1;
    #1;
    model_reset();
    check_model(tag);
    #1 reset = 1'b0;
  endtask

  typedef struct {
    bit         rst;
    bit         nc;
    bit         lc;
    logic [7:0] ch;
    bit         st;
    bit         cl;
    int         lvl;
    logic [8:0] dat;
    int         pkt;
    bit         ovf;
    bit         af;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit rst, input bit nc, input bit lc, input logic [7:0] ch,
                     input bit st, input bit cl, input int lvl, input logic [8:0] dat,
                     input int pkt, input bit ovf, input bit af);
    vec_t v;
    v.rst = rst; v.nc = nc; v.lc = lc; v.ch = ch; v.st = st; v.cl = cl;
    v.lvl = lvl; v.dat = dat; v.pkt = pkt; v.ovf = ovf; v.af = af;
    tbl.push_back(v);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Fill to full, overflow, clear; then control-character filtering.
    add(1, 0, 0, 8'h00, 0, 0, 0, 9'h000, 0, 0, 0);
    for (int i = 0; i < 8; i++)
      add(0, 1, 0, 8'(8'h41 + i), 0, 0, i + 1, 9'h041, 0, 0, (i + 1) >= AFL);
    add(0, 1, 0, 8'h49, 0, 0, 8, 9'h041, 0, 1, 1);
    add(0, 0, 0, 8'h00, 0, 1, 8, 9'h041, 0, 0, 1);
    add(1, 0, 1, 8'h00, 0, 0, 0, 9'h000, 0, 0, 0);
    add(0, 0, 1, 8'h03, 0, 0, 0, 9'h000, 0, 0, 0);
    add(0, 0, 1, 8'h01, 0, 0, 1, 9'h101, 1, 0, 0);
    add(0, 0, 1, 8'h02, 0, 0, 2, 9'h101, 2, 0, 0);
    add(0, 1, 1, 8'h06, 0, 0, 3, 9'h101, 3, 0, 0);
    add(0, 0, 0, 8'h00, 1, 0, 3, 9'h101, 3, 0, 0);
    add(0, 0, 0, 8'h00, 0, 0, 2, 9'h102, 2, 0, 0);

    foreach (tbl[k]) begin
      if (tbl[k].rst) do_reset($sformatf("v%0d rst", k));
      step(tbl[k].nc, tbl[k].lc, tbl[k].ch, tbl[k].st, tbl[k].cl, $sformatf("v%0d", k));
      chk($sformatf("v%0d tbl level", k), 32'(level_o), tbl[k].lvl);
      chk($sformatf("v%0d tbl pkt", k),   32'(pkt_cnt_o), tbl[k].pkt);
      chk($sformatf("v%0d tbl ovf", k),   32'(ovf_o), 32'(tbl[k].ovf));
      chk($sformatf("v%0d tbl afull", k), 32'(almost_full_o), 32'(tbl[k].af));
      if (tbl[k].lvl > 0) chk($sformatf("v%0d tbl dat", k), 32'(dat_o), 32'(tbl[k].dat));
    end

    // New overflow coinciding with a clear keeps the flag set.
    do_reset("ovfclr rst");
    for (int i = 0; i < 8; i++) step(1, 0, 8'(8'h10 + i), 0, 0, "ovfclr fill");
    step(1, 0, 8'h70, 0, 1, "ovfclr both");
    chk("ovfclr wins", 32'(ovf_o), 1);

    // Write into a full queue in the same cycle as a pop.
    do_reset("wrpop rst");
    for (int i = 0; i < 8; i++) step(1, 0, 8'(8'h60 + i), 0, 0, "wrpop fill");
    step(0, 0, 8'h00, 1, 0, "wrpop stb");
    step(1, 0, 8'h55, 0, 0, "wrpop both");
    chk("wrpop level", 32'(level_o), 8);
    chk("wrpop full", 32'(full_o), 1);
    chk("wrpop ovf", 32'(ovf_o), 0);
    for (int i = 0; i < 8; i++) step(0, 0, 8'h00, 1, 0, "wrpop drain");
    chk("wrpop 8th head", 32'(dat_o), 32'h055);
    chk("wrpop 8th level", 32'(level_o), 1);
    step(0, 0, 8'h00, 0, 0, "wrpop last");
    chk("wrpop empty", 32'(empty_o), 1);

    // Ack on an empty queue with a simultaneous write.
    do_reset("emptyack rst");
    step(0, 0, 8'h00, 1, 0, "emptyack stb");
    step(1, 0, 8'h22, 0, 0, "emptyack wr");
    chk("emptyack level", 32'(level_o), 1);
    chk("emptyack dat", 32'(dat_o), 32'h022);

    // Streaming with continuous strobe across pointer wrap.
    do_reset("stream rst");
    for (int i = 0; i < 20; i++) step(1, 0, 8'(8'h80 + i), 1, 0, "stream");
    step(0, 0, 8'h00, 0, 0, "stream drain");
    step(0, 0, 8'h00, 0, 0, "stream idle");
    chk("stream level0", 32'(level_o), 0);

    // Writes and strobes held across an edge during reset are ignored.
    @(negedge clk);
    reset = 1'b1; nchar = 1'b1; char_i = 8'h33; stb_i = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    check_model("inrst");
    @(negedge clk);
    reset = 1'b0; nchar = 1'b0; stb_i = 1'b0;
    step(0, 0, 8'h00, 1, 0, "postrst stb");
    chk("postrst ack", 32'(ack_o), 1);
    chk("postrst level", 32'(level_o), 0);

    // Asynchronous reset mid-cycle at level 5 with overflow pending.
    do_reset("async rst0");
    for (int i = 0; i < 9; i++) step(1, 0, 8'(8'hA0 + i), 0, 0, "async fill");
    step(0, 0, 8'h00, 1, 0, "async p0");
    step(0, 0, 8'h00, 1, 0, "async p1");
    step(0, 0, 8'h00, 1, 0, "async p2");
    step(0, 0, 8'h00, 0, 0, "async p3");
    chk("async pre level", 32'(level_o), 5);
    chk("async pre ovf", 32'(ovf_o), 1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_model("async");
    chk("async ack", 32'(ack_o), 0);
    chk("async level", 32'(level_o), 0);
    chk("async ovf", 32'(ovf_o), 0);
    chk("async empty", 32'(empty_o), 1);
    #1 reset = 1'b0;

    // Random traffic, alternating write-heavy and read-heavy phases.
    do_reset("rand rst");
    for (int i = 0; i < 1500; i++) begin
      logic nc, lc, st, cl;
      logic [7:0] ch;
      int wpct;
      wpct = ((i / 150) % 2 == 0) ? 75 : 30;
      nc = ($urandom_range(99) < wpct);
      lc = ($urandom_range(99) < 25);
      ch = 8'($urandom);
      st = ($urandom_range(99) < (100 - wpct));
      cl = ($urandom_range(99) < 5);
      step(nc, lc, ch, st, cl, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rx_char_fifo_p.md
RX_CHAR_FIFO_P -- requirements
Module: rx_char_fifo_p

Interface
REQ-001 Parameter DEPTH_LOG2, default 3; queue depth is DEPTH = 2**DEPTH_LOG2 entries.
REQ-002 Parameter AFULL_LEVEL, default DEPTH-2; almost_full_o threshold, legal range 1..DEPTH.
REQ-003 Parameter KEEP_CTRL, default 0; 1 = store every lchar code, 0 = store only EOP/EEP.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-high; clears all state.
REQ-006 nchar  input  1  data character present on char_i this cycle.
REQ-007 lchar  input  1  control character present on char_i this cycle.
REQ-008 char_i  input  8  character payload.
REQ-009 stb_i  input  1  read strobe.
REQ-010 ack_o  output  1  read acknowledge; head is popped in the ack_o cycle.
REQ-011 dat_o  output  9  head entry {lchar flag, char}.
REQ-012 full_o  output  1  level == DEPTH.
REQ-013 empty_o  output  1  level == 0.
REQ-014 almost_full_o  output  1  level >= AFULL_LEVEL.
REQ-015 level_o  output  DEPTH_LOG2+1  entries held, 0..DEPTH.
REQ-016 pkt_cnt_o  output  DEPTH_LOG2+1  stored entries with bit 8 set and char[1:0] in {01,10}.
REQ-017 ovf_o  output  1  sticky overflow flag.
REQ-018 ovf_clr_i  input  1  synchronous clear of ovf_o.

Function
REQ-019 Write request we = nchar | (lchar & (is_eop | KEEP_CTRL)); is_eop = char_i[1:0] in {01,10}.
REQ-020 nchar and lchar both high: treated as lchar; entry stored once.
REQ-021 Write accepted when we & (~full_o | pop this cycle); stores {lchar, char_i} at wp, wp wraps DEPTH-1 -> 0.
REQ-022 Write with full_o and no pop: dropped, ovf_o set next cycle; contents, pointers unchanged.
REQ-023 ack_o registered: high in cycle N+1 iff stb_i high in cycle N; continuous stb_i gives continuous ack_o.
REQ-024 Pop occurs in each ack_o cycle where empty_o is low; rp wraps DEPTH-1 -> 0.
REQ-025 ack_o while empty: no pop, even if write in same cycle; written entry appears next cycle.
REQ-026 dat_o = queue[rp] combinationally; value undefined when empty_o high.
REQ-027 Simultaneous accepted write and pop: level_o unchanged.
REQ-028 level_o, full_o, empty_o, almost_full_o, pkt_cnt_o update the cycle after the causing edge, no further latency.
REQ-029 pkt_cnt_o +1 on stored EOP/EEP, -1 on popped EOP/EEP; both same cycle: unchanged.
REQ-030 ovf_clr_i clears ovf_o; simultaneous new overflow wins (ovf_o stays 1).

Reset
REQ-031 reset asserted: ack_o=0, level_o=0, pkt_cnt_o=0, ovf_o=0, rp=wp=0, empty_o=1, full_o=0, almost_full_o=0, immediately and asynchronously.
REQ-032 Queue storage not reset; reset mid-operation discards all entries.
REQ-033 Writes and strobes during reset ignored; first stb_i after release gives ack_o one cycle later.

Structure
REQ-034 Shared package holds EOP=2'b01, EEP=2'b10 codes, is_eop function, and the 9-bit entry type.
REQ-035 One sub-module rx_fifo_ram (DEPTH x 9, 1 write port, async read) holds storage; control logic in top.
REQ-036 Level derived from a DEPTH_LOG2+1 counter, not pointer subtraction.

Verification (DEPTH_LOG2=3, AFULL_LEVEL=6, KEEP_CTRL=0)
REQ-037 Write nchar 0x41..0x48 (8) -> full_o=1, level_o=8, almost_full_o=1 from level 6; 9th write -> ovf_o=1, dat_o=0x041.
REQ-038 lchar char_i=0x00 (FCT) and 0x03 (ESC) -> nothing stored; lchar 0x01 -> dat_o=0x101, pkt_cnt_o=1.
REQ-039 Full queue, write 0x55 and ack_o same cycle -> level_o stays 8, 0x55 emerges 8th after pops.
REQ-040 Empty queue, stb_i one cycle plus write 0x22 on ack_o cycle -> no pop, level_o=1, dat_o=0x022.
REQ-041 Write/read 20 chars continuous stb_i -> order preserved across pointer wrap, level_o returns 0.
REQ-042 Async reset mid-fill at level 5, ovf_o=1 -> all outputs at reset values before next clk edge.
